// File: rtl/barrel_shifter_pkg.sv
// Shared types for the barrel shifter: the 2-bit operation encoding.
// Optional flag outputs are enabled with BARREL_SHIFTER_FLAGS_EN.
package barrel_shifter_pkg;

   typedef enum logic [1:0] {
      MODE_LSL = 2'b00,
      MODE_LSR = 2'b01,
      MODE_ROL = 2'b10,
      MODE_ROR = 2'b11
   } mode_e;

endpackage : barrel_shifter_pkg

// File: rtl/barrel_shifter_if.sv
// Operand/result bundle for the barrel shifter.
// zero/carry flag signals exist only with BARREL_SHIFTER_FLAGS_EN.
interface barrel_shifter_if
   import barrel_shifter_pkg::*;
#(
   parameter int WIDTH = 4
);
   localparam int SHW = $clog2(WIDTH);

   logic             in_valid;
   logic [WIDTH-1:0] data_in;
   logic [SHW-1:0]   shift;
   mode_e            mode;
   logic             out_valid;
   logic [WIDTH-1:0] data_out;
`ifdef BARREL_SHIFTER_FLAGS_EN
   logic             zero;
   logic             carry;
`endif

   modport master (
      output in_valid, data_in, shift, mode,
`ifdef BARREL_SHIFTER_FLAGS_EN
      input  zero, carry,
`endif
      input  out_valid, data_out
   );

   modport slave (
      input  in_valid, data_in, shift, mode,
`ifdef BARREL_SHIFTER_FLAGS_EN
      output zero, carry,
`endif
      output out_valid, data_out
   );

endinterface : barrel_shifter_if

// File: rtl/barrel_shifter_core.sv
// Combinational log-structured shift/rotate network: stage k moves by 2^k.
// The carry output is built only with BARREL_SHIFTER_FLAGS_EN.
module barrel_shifter_core
   import barrel_shifter_pkg::*;
#(
   parameter  int WIDTH = 4,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] data_i,
   input  logic [SHW-1:0]   shift_i,
   input  mode_e            mode_i,
`ifdef BARREL_SHIFTER_FLAGS_EN
   output logic             carry_o,
`endif
   output logic [WIDTH-1:0] result_o
);

   function automatic logic [WIDTH-1:0] stage_shift(input logic [WIDTH-1:0] x,
                                                    input int amt, input mode_e m);
      case (m)
         MODE_LSL: stage_shift = x << amt;
         MODE_LSR: stage_shift = x >> amt;
         MODE_ROL: stage_shift = (x << amt) | (x >> (WIDTH - amt));
         default:  stage_shift = (x >> amt) | (x << (WIDTH - amt));
      endcase
   endfunction

   logic [WIDTH-1:0] net;

   always_comb begin
      // NOTE: blocking assignments here so each stage feeds the next within one evaluation.
      net = data_i;
      for (int k = 0; k < SHW; k++) begin
         if (shift_i[k]) net = stage_shift(net, 1 << k, mode_i);
      end
   end

   assign result_o = net;

`ifdef BARREL_SHIFTER_FLAGS_EN
   logic [SHW-1:0] lsl_idx;
   logic [SHW-1:0] lsr_idx;

   // Last bit to leave the word: WIDTH-shift (mod WIDTH) for left, shift-1 for right.
   always_comb begin
      lsl_idx = ~shift_i + SHW'(1);
      lsr_idx = shift_i - SHW'(1);
      carry_o = 1'b0;
      if (shift_i != '0) begin
         case (mode_i)
            MODE_LSL: carry_o = data_i[lsl_idx];
            MODE_LSR: carry_o = data_i[lsr_idx];
            MODE_ROL: carry_o = net[0];
            default:  carry_o = net[WIDTH-1];
         endcase
      end
   end
`endif

endmodule : barrel_shifter_core

// File: rtl/barrel_shifter.sv
// Barrel shifter top: one register stage with valid and synchronous reset around the core.
// BARREL_SHIFTER_FLAGS_EN adds registered zero/carry flags.
module barrel_shifter
   import barrel_shifter_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   barrel_shifter_if.slave bus
);

   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] data_d, data_q;
   logic             valid_d, valid_q;

`ifdef BARREL_SHIFTER_FLAGS_EN
   logic carry;
   logic zero_d, zero_q;
   logic carry_d, carry_q;
`endif

   barrel_shifter_core #(.WIDTH(WIDTH)) u_core (
      .data_i   (bus.data_in),
      .shift_i  (bus.shift),
      .mode_i   (bus.mode),
`ifdef BARREL_SHIFTER_FLAGS_EN
      .carry_o  (carry),
`endif
      .result_o (result)
   );

   always_comb begin
      // NOTE: every output gets a hold default first, so no path leaves it unassigned (no latch).
      valid_d = bus.in_valid;
      data_d  = data_q;
`ifdef BARREL_SHIFTER_FLAGS_EN
      zero_d  = zero_q;
      carry_d = carry_q;
`endif
      if (bus.in_valid) begin
         data_d  = result;
`ifdef BARREL_SHIFTER_FLAGS_EN
         zero_d  = (result == '0);
         carry_d = carry;
`endif
      end
   end

   // NOTE: non-blocking assignments for all registered state.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
`ifdef BARREL_SHIFTER_FLAGS_EN
         zero_q  <= 1'b0;
         carry_q <= 1'b0;
`endif
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
`ifdef BARREL_SHIFTER_FLAGS_EN
         zero_q  <= zero_d;
         carry_q <= carry_d;
`endif
      end
   end

   assign bus.out_valid = valid_q;
   assign bus.data_out  = data_q;
`ifdef BARREL_SHIFTER_FLAGS_EN
   assign bus.zero      = zero_q;
   assign bus.carry     = carry_q;
`endif

endmodule : barrel_shifter

// File: tb/tb_barrel_shifter.sv
// Scoreboard bench for barrel_shifter: directed vectors push expected results, a monitor compares.
// Flag checks are included when BARREL_SHIFTER_FLAGS_EN is defined.
module tb_barrel_shifter;
   import barrel_shifter_pkg::*;

   localparam int WIDTH = 4;

   typedef struct {
      string            name;
      logic             valid;
      logic [WIDTH-1:0] data;
      logic             zero;
      logic             carry;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];

   barrel_shifter_if #(.WIDTH(WIDTH)) bus ();

   barrel_shifter #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, req);
      end
   endtask

   // Inputs change 1 time unit after the edge; the expectation is for the next edge.
   task automatic apply(input string name, input logic r, input logic v, input logic [3:0] d,
                        input logic [1:0] s, input mode_e m, input logic ev, input logic [3:0] ed,
                        input logic ez, input logic ec);
      exp_t e;
      @(posedge clk);
      #1;
      rst          = r;
      bus.in_valid = v;
      bus.data_in  = d;
      bus.shift    = s;
      bus.mode     = m;
      e.name = name; e.valid = ev; e.data = ed; e.zero = ez; e.carry = ec;
      exp_q.push_back(e);
   endtask

   // Monitor: pop the entry that applies to this edge, compare away from the edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            @(negedge clk);
            check({e.name, ".valid"}, WIDTH'(bus.out_valid), WIDTH'(e.valid));
            check({e.name, ".data"}, bus.data_out, e.data);
`ifdef BARREL_SHIFTER_FLAGS_EN
            check({e.name, ".zero"}, WIDTH'(bus.zero), WIDTH'(e.zero));
            check({e.name, ".carry"}, WIDTH'(bus.carry), WIDTH'(e.carry));
`endif
         end
      end
   end

   initial begin
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.data_in  = '0;
      bus.shift    = '0;
      bus.mode     = MODE_LSL;

      //     name        rst   v     data     sh     mode      ev    exp      z     c
      apply("rst0",     1'b1, 1'b0, 4'b0000, 2'd0, MODE_LSL, 1'b0, 4'b0000, 1'b0, 1'b0);
      apply("rst_prio", 1'b1, 1'b1, 4'b1111, 2'd1, MODE_LSL, 1'b0, 4'b0000, 1'b0, 1'b0);
      apply("lsl_1",    1'b0, 1'b1, 4'b1010, 2'd1, MODE_LSL, 1'b1, 4'b0100, 1'b0, 1'b1);
      apply("lsl_2",    1'b0, 1'b1, 4'b1010, 2'd2, MODE_LSL, 1'b1, 4'b1000, 1'b0, 1'b0);
      apply("lsr_1",    1'b0, 1'b1, 4'b1010, 2'd1, MODE_LSR, 1'b1, 4'b0101, 1'b0, 1'b0);
      apply("lsr_2",    1'b0, 1'b1, 4'b1010, 2'd2, MODE_LSR, 1'b1, 4'b0010, 1'b0, 1'b1);
      apply("rol_1",    1'b0, 1'b1, 4'b1010, 2'd1, MODE_ROL, 1'b1, 4'b0101, 1'b0, 1'b1);
      apply("rol_3",    1'b0, 1'b1, 4'b1010, 2'd3, MODE_ROL, 1'b1, 4'b0101, 1'b0, 1'b1);
      apply("ror_1",    1'b0, 1'b1, 4'b1010, 2'd1, MODE_ROR, 1'b1, 4'b0101, 1'b0, 1'b0);
      apply("ror_3",    1'b0, 1'b1, 4'b1010, 2'd3, MODE_ROR, 1'b1, 4'b0101, 1'b0, 1'b0);
      apply("asym_rol", 1'b0, 1'b1, 4'b0001, 2'd3, MODE_ROL, 1'b1, 4'b1000, 1'b0, 1'b0);
      apply("asym_ror", 1'b0, 1'b1, 4'b0001, 2'd3, MODE_ROR, 1'b1, 4'b0010, 1'b0, 1'b0);
      apply("asym_lsl", 1'b0, 1'b1, 4'b0001, 2'd3, MODE_LSL, 1'b1, 4'b1000, 1'b0, 1'b0);
      apply("asym_lsr", 1'b0, 1'b1, 4'b0001, 2'd3, MODE_LSR, 1'b1, 4'b0000, 1'b1, 1'b0);
      apply("flag_zc",  1'b0, 1'b1, 4'b1000, 2'd1, MODE_LSL, 1'b1, 4'b0000, 1'b1, 1'b1);
      apply("lsl_0",    1'b0, 1'b1, 4'b0110, 2'd0, MODE_LSL, 1'b1, 4'b0110, 1'b0, 1'b0);
      apply("lsr_0",    1'b0, 1'b1, 4'b0110, 2'd0, MODE_LSR, 1'b1, 4'b0110, 1'b0, 1'b0);
      apply("rol_0",    1'b0, 1'b1, 4'b1001, 2'd0, MODE_ROL, 1'b1, 4'b1001, 1'b0, 1'b0);
      apply("ror_0",    1'b0, 1'b1, 4'b1001, 2'd0, MODE_ROR, 1'b1, 4'b1001, 1'b0, 1'b0);
      apply("rol_2",    1'b0, 1'b1, 4'b1011, 2'd2, MODE_ROL, 1'b1, 4'b1110, 1'b0, 1'b0);
      apply("ror_1b",   1'b0, 1'b1, 4'b1011, 2'd1, MODE_ROR, 1'b1, 4'b1101, 1'b0, 1'b1);
      apply("lsl_3",    1'b0, 1'b1, 4'b1011, 2'd3, MODE_LSL, 1'b1, 4'b1000, 1'b0, 1'b1);
      apply("hold_a",   1'b0, 1'b0, 4'b0111, 2'd1, MODE_LSR, 1'b0, 4'b1000, 1'b0, 1'b1);
      apply("hold_b",   1'b0, 1'b0, 4'b0011, 2'd2, MODE_ROL, 1'b0, 4'b1000, 1'b0, 1'b1);
      apply("rst_mid",  1'b1, 1'b1, 4'b0101, 2'd1, MODE_LSL, 1'b0, 4'b0000, 1'b0, 1'b0);
      apply("post_rst", 1'b0, 1'b1, 4'b0011, 2'd1, MODE_LSL, 1'b1, 4'b0110, 1'b0, 1'b0);
      apply("hold_c",   1'b0, 1'b0, 4'b1111, 2'd3, MODE_ROR, 1'b0, 4'b0110, 1'b0, 1'b0);
      apply("rst_end",  1'b1, 1'b0, 4'b0000, 2'd0, MODE_LSL, 1'b0, 4'b0000, 1'b0, 1'b0);
      apply("idle_r1",  1'b0, 1'b0, 4'b1100, 2'd2, MODE_LSR, 1'b0, 4'b0000, 1'b0, 1'b0);
      apply("idle_r2",  1'b0, 1'b0, 4'b0110, 2'd1, MODE_ROL, 1'b0, 4'b0000, 1'b0, 1'b0);

      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d results still pending, expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_barrel_shifter

// File: doc/barrel_shifter.md
BARREL_SHIFTER -- requirements
Module: barrel_shifter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the data word width in bits (power of two, at least 2).
REQ-002 The block SHALL have localparam SHW, equal to $clog2(WIDTH), giving the shift-amount width.
REQ-003 The block SHALL have port `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port `rst`, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port `in_valid`, input, 1 bit: qualifies `data_in`, `shift` and `mode` this cycle.
REQ-006 The block SHALL have port `data_in`, input, WIDTH bits: operand.
REQ-007 The block SHALL have port `shift`, input, SHW bits: unsigned shift/rotate amount, 0..WIDTH-1.
REQ-008 The block SHALL have port `mode`, input, 2 bits: 00 logical left, 01 logical right, 10 rotate left, 11 rotate right.
REQ-009 The block SHALL have port `out_valid`, output, 1 bit: `data_out` holds a new result this cycle.
REQ-010 The block SHALL have port `data_out`, output, WIDTH bits: registered result.

Function
REQ-011 Mode 00 SHALL produce data_in << shift, zero-filling the low bits.
REQ-012 Mode 01 SHALL produce data_in >> shift, zero-filling the high bits; there is no sign extension.
REQ-013 Mode 10 SHALL produce a rotate left: bit i of the result equals data_in[(i - shift) mod WIDTH].
REQ-014 Mode 11 SHALL produce a rotate right: bit i of the result equals data_in[(i + shift) mod WIDTH].
REQ-015 With shift = 0, every mode SHALL pass data_in through unchanged.
REQ-016 Latency SHALL be exactly 1 cycle: inputs sampled at edge N with in_valid=1 appear on data_out, with out_valid=1, after edge N.
REQ-017 When in_valid=0 at an edge, out_valid SHALL go 0 and data_out SHALL hold its previous value.
REQ-018 The block SHALL accept one operation per cycle with no backpressure; back-to-back valid inputs produce back-to-back results.
REQ-019 The shift network SHALL be log-structured: SHW mux stages, stage k shifting by 2^k when shift[k]=1.

Reset
REQ-020 While rst=1 at a rising edge, data_out SHALL load all-zeros and out_valid SHALL load 0.
REQ-021 rst SHALL take priority over in_valid; an operation presented in a reset cycle is discarded.
REQ-022 In the first edge after rst deasserts, normal sampling SHALL resume with no extra latency.

Configuration
REQ-023 With macro BARREL_SHIFTER_FLAGS_EN defined, the block SHALL add registered output ports `zero` (1 bit) and `carry` (1 bit), timed with data_out.
REQ-024 `zero` SHALL be 1 when the result is all zeros.
REQ-025 `carry` SHALL be the last bit shifted out: data_in[WIDTH-shift] for mode 00 and data_in[shift-1] for mode 01.
REQ-026 For mode 10, `carry` SHALL equal result[0]; for mode 11, it SHALL equal result[WIDTH-1].
REQ-027 `carry` SHALL be 0 whenever shift = 0.
REQ-028 Both flags SHALL reset to 0 and SHALL hold their values when in_valid=0.
REQ-029 Without BARREL_SHIFTER_FLAGS_EN, the `zero` and `carry` ports and their logic SHALL be absent.

Structure
REQ-030 Package barrel_shifter_pkg SHALL hold the mode encoding typedef (MODE_LSL, MODE_LSR, MODE_ROL, MODE_ROR).
REQ-031 The combinational log-stage network SHALL live in sub-module barrel_shifter_core (data, shift, mode in; result and carry out).
REQ-032 barrel_shifter SHALL add only the valid/reset register stage around barrel_shifter_core.

Verification
REQ-033 Logical left: data_in=1010 with shift=1, then shift=2, mode=00 -> data_out=0100, then 1000, each one cycle later with out_valid=1.
REQ-034 Logical right: data_in=1010 with shift=1, then shift=2, mode=01 -> data_out=0101, then 0010.
REQ-035 Rotates: data_in=1010 with shift=1, then shift=3 -> mode=10 gives 0101, then 0101; mode=11 gives 0101, then 0101.
REQ-036 Rotates on an asymmetric operand: data_in=0001, shift=3 -> mode=10 gives 1000; mode=11 gives 0010; mode=00 gives 1000; mode=01 gives 0000.
REQ-037 Reset and hold: result present, then rst=1 -> data_out=0000 and out_valid=0; in_valid=0 cycles after reset -> data_out holds.
REQ-038 Flags build: data_in=1000, shift=1, mode=00 -> data_out=0000, zero=1, carry=1; shift=0 in any mode -> carry=0.
